// File: rtl/mux_pkg.sv
// Shared mode encodings and sizing helper for the registered channel selector
// and the round-robin pick logic it uses.
package mux_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Never returns 0, so a degenerate channel count still yields a usable index
    function automatic int selWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first asserted request at or above ptr,
// wrapping at N (not at a power of two).
module rr_pick #(
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    int               w_pos;
    logic [SEL_W-1:0] w_cand;

    // ptr is always kept below N by the owner, so one subtraction is enough to wrap
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_pos  = 0;
        w_cand = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = int'(ptr) + i;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_cand = SEL_W'(w_pos);
            if (!found && req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-channel selector with direct/scan/hold modes, per-channel ack and
// a one-deep valid/ready output register.
module mux_n_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH = 6,
    parameter  int N     = 8,
    localparam int SEL_W = selWidth(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_bus,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ack,
    input  logic [1:0]         mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    output logic               sel_err
);

    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_outData;
    logic [SEL_W-1:0] r_outSel;
    logic             r_outValid;
    logic             r_selErr;

    logic             w_loadEn;
    logic             w_selLegal;
    logic             w_found;
    logic [SEL_W-1:0] w_pickIdx;
    logic             w_capture;
    logic             w_scanCap;
    logic [SEL_W-1:0] w_capIdx;
    logic             w_err;
    logic [WIDTH-1:0] w_capData;
    logic [SEL_W-1:0] w_ptrNext;

    assign w_loadEn   = !r_outValid || out_ready;
    assign w_selLegal = int'(sel) < N;

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req   (in_valid),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_pickIdx)
    );

    always_comb begin
        w_capture = 1'b0;
        w_scanCap = 1'b0;
        w_capIdx  = '0;
        w_err     = 1'b0;
        case (mode)
            MODE_DIRECT: begin
                if (!w_selLegal) begin
                    w_err = 1'b1;
                end else if (in_valid[sel] && w_loadEn) begin
                    w_capture = 1'b1;
                    w_capIdx  = sel;
                end
            end
            MODE_SCAN: begin
                if (w_found && w_loadEn) begin
                    w_capture = 1'b1;
                    w_scanCap = 1'b1;
                    w_capIdx  = w_pickIdx;
                end
            end
            MODE_RSVD: w_err = 1'b1;
            default: ;
        endcase
    end

    assign w_capData = in_bus[w_capIdx*WIDTH +: WIDTH];
    assign w_ptrNext = (w_capIdx == SEL_W'(N - 1)) ? '0 : w_capIdx + 1'b1;

    // Ack is suppressed during reset so no source believes its word was taken
    always_comb begin
        in_ack = '0;
        if (w_capture && rst_n) begin
            in_ack[w_capIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outData  <= '0;
            r_outSel   <= '0;
            r_outValid <= 1'b0;
            r_selErr   <= 1'b0;
            r_ptr      <= '0;
        end else begin
            r_selErr <= w_err;
            if (w_capture) begin
                r_outData  <= w_capData;
                r_outSel   <= w_capIdx;
                r_outValid <= 1'b1;
            end else if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
            if (w_scanCap) begin
                r_ptr <= w_ptrNext;
            end
        end
    end

    assign out_data  = r_outData;
    assign out_sel   = r_outSel;
    assign out_valid = r_outValid;
    assign sel_err   = r_selErr;

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed bench for mux_n_reg: an 8-channel instance (A) and a 6-channel
// instance (B) sharing clock and reset.
module tb_mux_n_reg;

    localparam int WIDTH = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [8*WIDTH-1:0] aBus;
    logic [7:0]         aValid, aAck;
    logic [1:0]         aMode;
    logic [2:0]         aSel, aOutSel;
    logic               aReady, aOutValid, aErr;
    logic [WIDTH-1:0]   aData;

    logic [6*WIDTH-1:0] bBus;
    logic [5:0]         bValid, bAck;
    logic [1:0]         bMode;
    logic [2:0]         bSel, bOutSel;
    logic               bReady, bOutValid, bErr;
    logic [WIDTH-1:0]   bData;

    mux_n_reg #(.WIDTH(WIDTH), .N(8)) dutA (
        .clk(clk), .rst_n(rst_n), .in_bus(aBus), .in_valid(aValid), .in_ack(aAck),
        .mode(aMode), .sel(aSel), .out_ready(aReady), .out_data(aData),
        .out_sel(aOutSel), .out_valid(aOutValid), .sel_err(aErr)
    );

    mux_n_reg #(.WIDTH(WIDTH), .N(6)) dutB (
        .clk(clk), .rst_n(rst_n), .in_bus(bBus), .in_valid(bValid), .in_ack(bAck),
        .mode(bMode), .sel(bSel), .out_ready(bReady), .out_data(bData),
        .out_sel(bOutSel), .out_valid(bOutValid), .sel_err(bErr)
    );

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [2:0] s, input logic [7:0] v, input logic r);
        aMode  = m;
        aSel   = s;
        aValid = v;
        aReady = r;
        #1;
    endtask

    task automatic applyStimulusB(input logic [1:0] m, input logic [2:0] s, input logic [5:0] v, input logic r);
        bMode  = m;
        bSel   = s;
        bValid = v;
        bReady = r;
        #1;
    endtask

    initial begin
        int scanA[5];
        int scanB[4];
        scanA = '{2, 5, 7, 2, 5};
        scanB = '{0, 5, 0, 5};

        rst_n = 1'b0;
        for (int k = 0; k < 8; k++) aBus[k*WIDTH +: WIDTH] = 6'(8 + k);
        for (int k = 0; k < 6; k++) bBus[k*WIDTH +: WIDTH] = 6'(32 + k);
        aMode = 2'b00; aSel = 3'd0; aValid = 8'hFF; aReady = 1'b1;
        bMode = 2'b10; bSel = 3'd0; bValid = 6'h00; bReady = 1'b1;

        #1;
        checkOutput("rst_valid", 32'(aOutValid), 32'd0);
        checkOutput("rst_data",  32'(aData),     32'd0);
        checkOutput("rst_sel",   32'(aOutSel),   32'd0);
        checkOutput("rst_err",   32'(aErr),      32'd0);
        checkOutput("rst_ack",   32'(aAck),      32'd0);
        aMode = 2'b10;
        #1 rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            applyStimulus(2'b00, 3'(k), 8'hFF, 1'b1);
            checkOutput($sformatf("dir_ack%0d", k), 32'(aAck), 32'(1 << k));
            tick();
            checkOutput($sformatf("dir_data%0d", k),  32'(aData),     32'(8 + k));
            checkOutput($sformatf("dir_sel%0d", k),   32'(aOutSel),   32'(k));
            checkOutput($sformatf("dir_valid%0d", k), 32'(aOutValid), 32'd1);
        end

        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b01, 3'd0, 8'b1010_0100, 1'b1);
            checkOutput($sformatf("scan_ack%0d", i), 32'(aAck), 32'(1 << scanA[i]));
            tick();
            checkOutput($sformatf("scan_sel%0d", i),  32'(aOutSel), 32'(scanA[i]));
            checkOutput($sformatf("scan_data%0d", i), 32'(aData),   32'(8 + scanA[i]));
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b00, 3'd3, 8'hFF, 1'b0);
            checkOutput($sformatf("bp_ack%0d", i), 32'(aAck), 32'd0);
            tick();
            checkOutput($sformatf("bp_valid%0d", i), 32'(aOutValid), 32'd1);
            checkOutput($sformatf("bp_data%0d", i),  32'(aData),     32'h0D);
            checkOutput($sformatf("bp_sel%0d", i),   32'(aOutSel),   32'd5);
        end
        applyStimulus(2'b00, 3'd3, 8'hFF, 1'b1);
        checkOutput("bp_rel_ack", 32'(aAck), 32'h08);
        tick();
        checkOutput("bp_rel_data",  32'(aData),     32'h0B);
        checkOutput("bp_rel_valid", 32'(aOutValid), 32'd1);
        applyStimulus(2'b00, 3'd6, 8'hFF, 1'b1);
        checkOutput("b2b_ack", 32'(aAck), 32'h40);
        tick();
        checkOutput("b2b_data",  32'(aData),     32'h0E);
        checkOutput("b2b_valid", 32'(aOutValid), 32'd1);

        applyStimulus(2'b10, 3'd0, 8'hFF, 1'b1);
        checkOutput("drain_ack", 32'(aAck), 32'd0);
        tick();
        checkOutput("drain_valid", 32'(aOutValid), 32'd0);
        checkOutput("drain_data",  32'(aData),     32'h0E);
        checkOutput("drain_sel",   32'(aOutSel),   32'd6);

        applyStimulus(2'b01, 3'd0, 8'b0000_1000, 1'b1);
        checkOutput("ptr4_ack", 32'(aAck), 32'h08);
        tick();
        checkOutput("ptr4_sel", 32'(aOutSel), 32'd3);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b10, 3'd0, 8'hFF, 1'b1);
            checkOutput($sformatf("hold_ack%0d", i), 32'(aAck), 32'd0);
            tick();
            checkOutput($sformatf("hold_valid%0d", i), 32'(aOutValid), 32'd0);
        end
        applyStimulus(2'b01, 3'd0, 8'hFF, 1'b1);
        checkOutput("resume_ack4", 32'(aAck), 32'h10);
        tick();
        checkOutput("resume_sel4",  32'(aOutSel), 32'd4);
        checkOutput("resume_data4", 32'(aData),   32'h0C);
        applyStimulus(2'b01, 3'd0, 8'hFF, 1'b1);
        checkOutput("resume_ack5", 32'(aAck), 32'h20);
        tick();
        checkOutput("resume_sel5", 32'(aOutSel), 32'd5);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b11, 3'd0, 8'hFF, 1'b0);
            checkOutput($sformatf("rsvd_ack%0d", i), 32'(aAck), 32'd0);
            tick();
            checkOutput($sformatf("rsvd_err%0d", i),   32'(aErr),      32'd1);
            checkOutput($sformatf("rsvd_valid%0d", i), 32'(aOutValid), 32'd1);
            checkOutput($sformatf("rsvd_data%0d", i),  32'(aData),     32'h0D);
        end
        applyStimulus(2'b10, 3'd0, 8'hFF, 1'b1);
        tick();
        checkOutput("rsvd_end_err",   32'(aErr),      32'd0);
        checkOutput("rsvd_end_valid", 32'(aOutValid), 32'd0);

        for (int i = 0; i < 4; i++) begin
            applyStimulusB(2'b01, 3'd0, 6'b10_0001, 1'b1);
            checkOutput($sformatf("n6_ack%0d", i), 32'(bAck), 32'(1 << scanB[i]));
            tick();
            checkOutput($sformatf("n6_sel%0d", i),  32'(bOutSel), 32'(scanB[i]));
            checkOutput($sformatf("n6_data%0d", i), 32'(bData),   32'(32 + scanB[i]));
        end
        applyStimulusB(2'b00, 3'd7, 6'h3F, 1'b1);
        checkOutput("n6_bad_ack", 32'(bAck), 32'd0);
        tick();
        checkOutput("n6_bad_err",   32'(bErr),      32'd1);
        checkOutput("n6_bad_valid", 32'(bOutValid), 32'd0);
        checkOutput("n6_bad_sel",   32'(bOutSel),   32'd5);
        applyStimulusB(2'b10, 3'd0, 6'h3F, 1'b1);
        tick();
        checkOutput("n6_err_clear", 32'(bErr), 32'd0);

        applyStimulus(2'b00, 3'd1, 8'hFF, 1'b1);
        tick();
        checkOutput("pre_rst_data", 32'(aData), 32'h09);
        applyStimulus(2'b11, 3'd0, 8'hFF, 1'b0);
        tick();
        checkOutput("pre_rst_err", 32'(aErr), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(aOutValid), 32'd0);
        checkOutput("arst_data",  32'(aData),     32'd0);
        checkOutput("arst_sel",   32'(aOutSel),   32'd0);
        checkOutput("arst_err",   32'(aErr),      32'd0);
        applyStimulus(2'b01, 3'd0, 8'hFF, 1'b1);
        checkOutput("arst_ack_gated", 32'(aAck), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("arst_ptr_ack", 32'(aAck), 32'h01);
        tick();
        checkOutput("arst_ptr_sel",  32'(aOutSel), 32'd0);
        checkOutput("arst_ptr_data", 32'(aData),   32'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
- Registered, parametrised N-channel, WIDTH-bit selector for the 6-bit CPU datapath.
- Generalises the 8-to-1 single-bit mux to buses of any width and channel count.
- Adds three selection modes: direct select, round-robin scan and hold.
- Adds per-channel valid/ack on the input side and a one-deep valid/ready output register, so ALU/register-file sources can be arbitrated onto one result bus.

Parameters:
- WIDTH, 6, bits per channel.
- N, 8, number of input channels (N >= 2; N need not be a power of two).
- SEL_W, $clog2(N), select/pointer width; derived localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_bus  in  N*WIDTH  packed channel data; channel k = in_bus[k*WIDTH +: WIDTH].
- in_valid  in  N  per-channel data-valid.
- in_ack  out  N  one-hot, combinational; high in the cycle channel k is captured.
- mode  in  2  00 DIRECT, 01 SCAN, 10 HOLD, 11 reserved.
- sel  in  SEL_W  channel index, used in DIRECT mode only.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SEL_W  index of the channel held in out_data.
- out_valid  out  1  out_data/out_sel are valid.
- sel_err  out  1  registered one-cycle pulse on an illegal sel or mode.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_data=0, out_sel=0, out_valid=0, sel_err=0, scan pointer ptr=0.
  - in_ack=0 while rst_n is low.
- Load condition: load_en = !out_valid || out_ready. Captures happen only when load_en=1.
- DIRECT:
  - If sel < N and in_valid[sel] and load_en: capture channel sel; in_ack[sel]=1.
  - If sel >= N: no capture, in_ack=0, sel_err=1 next cycle.
- SCAN:
  - Pick the first k with in_valid[k], searching from ptr upward and wrapping modulo N.
  - If load_en and a pick exists: capture channel k; in_ack[k]=1; ptr <= (k+1) mod N, with wrap at N, not 2^SEL_W.
  - No valid channel: no capture, ptr unchanged.
- HOLD: no capture, in_ack=0; output register keeps its contents and still drains normally through out_ready.
- Reserved mode 11: behaves as HOLD; sel_err=1 next cycle, and every cycle while mode=11.
- Capture timing: out_data <= channel data, out_sel <= k, out_valid <= 1 on the next rising edge. Latency is 1 cycle from in_valid/sel to out_valid.
- No capture but out_valid && out_ready: out_valid <= 0; out_data and out_sel retain their last values.
- Simultaneous drain and capture (out_valid=1, out_ready=1, pick exists): the new word replaces the old with no bubble, so throughput is 1 word/cycle.
- Backpressure (out_valid=1, out_ready=0): nothing captured, in_ack=0; out_data, out_sel and out_valid are stable until accepted.
- Mode change: takes effect in the same cycle; an occupied output register is unaffected; ptr is preserved across mode changes.
- sel_err: high for exactly one cycle per offending cycle and cleared otherwise; it does not block the output stage.
- Async reset mid-transfer: the in-flight word is discarded, out_valid drops immediately, and ptr returns to 0.

Decomposition:
- Package mux_pkg holds:
  - mode constants MODE_DIRECT=2'b00, MODE_SCAN=2'b01, MODE_HOLD=2'b10, MODE_RSVD=2'b11;
  - a clog2-safe SEL_W helper function.
- Sub-module rr_pick (combinational, params N, SEL_W):
  - inputs req[N], ptr;
  - outputs found, idx;
  - rotate-priority search reused by future bus arbiters.
- mux_n_reg holds the mode decode, output register, ptr register and sel_err.

Test Plan:
- Reset/defaults: assert rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_sel, sel_err go to 0 immediately, with no clock edge needed.
- DIRECT sweep (WIDTH=6, N=8): channel k = 6'h08+k, all in_valid=1, out_ready=1, sel=0..7 on successive cycles -> out_data = 6'h08..6'h0F one cycle later, out_sel tracks sel, in_ack one-hot.
- SCAN fairness: in_valid=8'b1010_0100, out_ready=1 -> capture order 2,5,7,2,5… with ptr wrapping 7->0. With N=6, in_valid=6'b10_0001 -> order 0,5,0,5.
- Backpressure: DIRECT sel=3, out_ready=0 for 4 cycles -> out_valid=1, out_data frozen, in_ack=0. Then out_ready=1 -> back-to-back capture with no bubble cycle.
- Errors: N=6 with sel=7 -> no capture, sel_err pulses for 1 cycle. mode=11 for 3 cycles -> sel_err high 3 cycles, output held, then drains on out_ready.
- HOLD/mode switch: switch SCAN->HOLD->SCAN with ptr=4 -> no captures during HOLD, and scanning resumes from channel 4.
